am_demod: RTL

- Receive-side counterpart of the AM cosine generator and mixer path.
- Accepts signed AM samples (offset-modulating tone × carrier product) and full-wave rectifies them.
- Integrate-and-dump low-pass over one rectified carrier half-period recovers the envelope.
- Optional DC blocker strips the modulation offset; output is the recovered modulating tone at the decimated rate.

---
 rtl/am_pkg.sv | 25 ++
 rtl/am_dc_block.sv | 61 ++++++
 rtl/am_demod.sv | 100 ++++++++++
 3 files changed

// File: rtl/am_pkg.sv
// Shared constants and helpers for the AM receive path (am_demod and friends).
// Optional build macro used by this slice: AM_DC_BLOCK_EN (enables the DC blocker).
package am_pkg;

  // Input sample: 9-bit offset tone times 8-bit signed carrier.
  localparam int unsigned AM_IN_W      = 17;
  // Unsigned envelope width.
  localparam int unsigned AM_ENV_W     = 16;
  // Valid samples per rectified carrier half-period (fclk/100 carrier).
  localparam int unsigned AM_DEC_LEN   = 50;
  // Largest legal window length; sizes both the counter and the accumulator.
  localparam int unsigned AM_DEC_MAX   = 255;
  // Window-sum to envelope scaling.
  localparam int unsigned AM_OUT_SHIFT = 6;
  // DC tracker IIR coefficient exponent (2^-AM_DC_SHIFT).
  localparam int unsigned AM_DC_SHIFT  = 4;
  // Window counter width, enough to count to AM_DEC_MAX-1.
  localparam int unsigned AM_CNT_W     = $clog2(AM_DEC_MAX + 1);

  // Accumulator width that cannot wrap when summing AM_DEC_MAX rectified samples.
  function automatic int unsigned am_acc_w(input int unsigned in_w);
    return in_w + $clog2(AM_DEC_MAX + 1);
  endfunction

endpackage

// File: rtl/am_dc_block.sv
// Stage 3 of the AM receive path: turns each envelope update into a demodulated sample.
// With AM_DC_BLOCK_EN a first-order DC tracker is subtracted; otherwise the envelope
// is passed through zero-extended. Output timing is one clock after env_valid either way.
module am_dc_block
  import am_pkg::*;
#(
  parameter int unsigned ENV_W    = AM_ENV_W
`ifdef AM_DC_BLOCK_EN
  ,
  parameter int unsigned DC_SHIFT = AM_DC_SHIFT
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ENV_W-1:0] env_in,
  input  logic             env_vld,
  output logic [ENV_W:0]   demod_out,
  output logic             demod_valid
);

`ifdef AM_DC_BLOCK_EN

  logic signed [ENV_W:0] dc;
  logic signed [ENV_W:0] diff_c;

  // Envelope minus the running DC estimate; both fit in ENV_W+1 signed bits.
  assign diff_c = $signed({1'b0, env_in}) - dc;

  // Emit the DC-free sample and move the tracker a fraction of the error toward the envelope.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc          <= '0;
      demod_out   <= '0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= env_vld;
      if (env_vld) begin
        demod_out <= diff_c;
        dc        <= dc + (diff_c >>> DC_SHIFT);
      end
    end
  end

`else

  // Pass the envelope through as a non-negative signed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      demod_out   <= '0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= env_vld;
      if (env_vld) begin
        demod_out <= {1'b0, env_in};
      end
    end
  end

`endif

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: full-wave rectify, integrate-and-dump over one rectified
// carrier half-period, saturate to the envelope width, then optional DC removal.
// Optional build macro: AM_DC_BLOCK_EN (adds the DC tracker in am_dc_block).
module am_demod
  import am_pkg::*;
#(
  parameter int unsigned IN_W      = AM_IN_W,
  parameter int unsigned DEC_LEN   = AM_DEC_LEN,
  parameter int unsigned OUT_SHIFT = AM_OUT_SHIFT,
  parameter int unsigned ENV_W     = AM_ENV_W
`ifdef AM_DC_BLOCK_EN
  ,
  parameter int unsigned DC_SHIFT  = AM_DC_SHIFT
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  am_in,
  input  logic             am_valid,
  output logic [ENV_W-1:0] env_out,
  output logic             env_valid,
  output logic [ENV_W:0]   demod_out,
  output logic             demod_valid
);

  localparam int unsigned      ACC_W    = am_acc_w(IN_W);
  localparam int unsigned      CNT_W    = AM_CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_LEN - 1);
  localparam logic [ACC_W-1:0] ENV_MAX  = ACC_W'((64'd1 << ENV_W) - 64'd1);

  logic [IN_W-1:0]  abs_c;
  logic [IN_W-1:0]  abs_r;
  logic             abs_vld;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_c;
  logic [ACC_W-1:0] shifted_c;
  logic [ENV_W-1:0] env_sat_c;

  // Two's-complement magnitude; the most negative input maps exactly to 2^(IN_W-1).
  assign abs_c = am_in[IN_W-1] ? (~am_in + IN_W'(1)) : am_in;

  // Stage 1: register the rectified sample; invalid cycles leave a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_r   <= '0;
      abs_vld <= 1'b0;
    end else begin
      abs_vld <= am_valid;
      if (am_valid) begin
        abs_r <= abs_c;
      end
    end
  end

  // Window total including the current sample, scaled and clamped to the envelope range.
  assign sum_c     = acc + ACC_W'(abs_r);
  assign shifted_c = sum_c >> OUT_SHIFT;
  assign env_sat_c = (shifted_c > ENV_MAX) ? ENV_W'(ENV_MAX) : ENV_W'(shifted_c);

  // Stage 2: integrate valid samples and dump the envelope on the last one of each window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      env_out   <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= 1'b0;
      if (abs_vld) begin
        if (cnt == CNT_LAST) begin
          env_out   <= env_sat_c;
          env_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Stage 3: demodulated output, one clock behind the envelope.
  am_dc_block #(
    .ENV_W    (ENV_W)
`ifdef AM_DC_BLOCK_EN
    ,
    .DC_SHIFT (DC_SHIFT)
`endif
  ) u_dc_block (
    .clk         (clk),
    .rst_n       (rst_n),
    .env_in      (env_out),
    .env_vld     (env_valid),
    .demod_out   (demod_out),
    .demod_valid (demod_valid)
  );

endmodule
